// File: rtl/note_step_engine.sv
// Polyphonic phase-increment engine: round-robin recomputation of per-voice
// 32-bit phase steps from note + pitch bend, using a one-octave base table.
module note_step_engine #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned CH_BITS      = 2,
  parameter int unsigned BEND_SEMIS   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [CH_BITS-1:0]        wr_ch,
  input  logic [6:0]                wr_note,
  input  logic [13:0]               wr_bend,
  input  logic                      wr_gate,
  output logic [32*NUM_CHANNELS-1:0] step_flat,
  output logic                      upd_valid,
  output logic [CH_BITS-1:0]        upd_ch
);

  localparam int unsigned STEP_W = 32;
  localparam int unsigned FRAC_W = 12;
  localparam int unsigned POS_W  = 24;

  typedef enum logic [2:0] {LOAD, DIV, LOOK, MUL, WRITE} state_e;

  // Top octave (MIDI notes 120..131 at 40 kHz); lower octaves are right shifts.
  function automatic logic [STEP_W-1:0] base_lut(input logic [3:0] k);
    case (k)
      4'd0:    base_lut = 32'd898938587;
      4'd1:    base_lut = 32'd952392247;
      4'd2:    base_lut = 32'd1009024459;
      4'd3:    base_lut = 32'd1069024176;
      4'd4:    base_lut = 32'd1132591661;
      4'd5:    base_lut = 32'd1199939066;
      4'd6:    base_lut = 32'd1271291156;
      4'd7:    base_lut = 32'd1346885960;
      4'd8:    base_lut = 32'd1426976075;
      4'd9:    base_lut = 32'd1511828480;
      4'd10:   base_lut = 32'd1601726488;
      4'd11:   base_lut = 32'd1696970102;
      default: base_lut = '0;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [CH_BITS-1:0]  ptr_q, ptr_d;
  logic [6:0]          note_q [NUM_CHANNELS];
  logic [6:0]          note_d [NUM_CHANNELS];
  logic [13:0]         bend_q [NUM_CHANNELS];
  logic [13:0]         bend_d [NUM_CHANNELS];
  logic                gate_q [NUM_CHANNELS];
  logic                gate_d [NUM_CHANNELS];
  logic [STEP_W-1:0]   step_q [NUM_CHANNELS];
  logic [STEP_W-1:0]   step_d [NUM_CHANNELS];
  logic [6:0]          rem_q, rem_d;
  logic [3:0]          oct_q, oct_d;
  logic [FRAC_W-1:0]   frac_q, frac_d;
  logic                gl_q, gl_d;
  logic [STEP_W-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
  logic                upd_valid_q, upd_valid_d;
  logic [CH_BITS-1:0]  upd_ch_q, upd_ch_d;

  logic [6:0]          sel_note;
  logic [13:0]         sel_bend;
  logic                sel_gate;
  logic signed [POS_W-1:0] bend_off, pos_raw;
  logic [18:0]         pos_cl;
  logic [3:0]          s_nb, o_nb;
  logic [43:0]         prod;
  logic                wr_hit;

  // Channel mux for the voice under the scan pointer
  always_comb begin
    sel_note = '0;
    sel_bend = '0;
    sel_gate = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (CH_BITS'(c) == ptr_q) begin
        sel_note = note_q[c];
        sel_bend = bend_q[c];
        sel_gate = gate_q[c];
      end
    end
  end

  // Bent pitch position in 1/4096 semitone, clamped to notes 0..127
  always_comb begin
    bend_off = ($signed({10'd0, sel_bend}) - 24'sd8192) * $signed(POS_W'(BEND_SEMIS));
    pos_raw  = $signed({5'd0, sel_note, 12'd0}) + (bend_off >>> 1);
    if (pos_raw < 24'sd0)           pos_cl = '0;
    else if (pos_raw > 24'sd520192) pos_cl = 19'd520192;
    else                            pos_cl = pos_raw[18:0];
  end

  assign wr_hit = 32'(wr_ch) < NUM_CHANNELS;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    note_d      = note_q;
    bend_d      = bend_q;
    gate_d      = gate_q;
    step_d      = step_q;
    rem_d       = rem_q;
    oct_d       = oct_q;
    frac_d      = frac_q;
    gl_d        = gl_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    upd_valid_d = 1'b0;
    upd_ch_d    = upd_ch_q;
    s_nb        = '0;
    o_nb        = '0;
    prod        = '0;

    if (wr_en && wr_hit) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (CH_BITS'(c) == wr_ch) begin
          note_d[c] = wr_note;
          bend_d[c] = wr_bend;
          gate_d[c] = wr_gate;
        end
      end
    end

    case (state_q)
      LOAD: begin
        rem_d   = pos_cl[18:12];
        frac_d  = pos_cl[11:0];
        oct_d   = '0;
        gl_d    = sel_gate;
        state_d = DIV;
      end
      DIV: begin
        if (rem_q >= 7'd12) begin
          rem_d = rem_q - 7'd12;
          oct_d = oct_q + 4'd1;
        end else begin
          state_d = LOOK;
        end
      end
      LOOK: begin
        if (rem_q[3:0] == 4'd11) begin
          s_nb = 4'd0;
          o_nb = oct_q + 4'd1;
        end else begin
          s_nb = rem_q[3:0] + 4'd1;
          o_nb = oct_q;
        end
        a_d     = base_lut(rem_q[3:0]) >> (4'd10 - oct_q);
        b_d     = base_lut(s_nb) >> (4'd10 - o_nb);
        state_d = MUL;
      end
      MUL: begin
        prod    = 44'(b_q - a_q) * 44'(frac_q);
        r_d     = a_q + prod[43:12];
        state_d = WRITE;
      end
      WRITE: begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          if (CH_BITS'(c) == ptr_q) step_d[c] = gl_q ? r_q : '0;
        end
        upd_valid_d = 1'b1;
        upd_ch_d    = ptr_q;
        ptr_d       = (ptr_q == CH_BITS'(NUM_CHANNELS - 1)) ? '0 : ptr_q + CH_BITS'(1);
        state_d     = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      ptr_q       <= '0;
      rem_q       <= '0;
      oct_q       <= '0;
      frac_q      <= '0;
      gl_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      upd_valid_q <= 1'b0;
      upd_ch_q    <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        note_q[c] <= '0;
        bend_q[c] <= 14'd8192;
        gate_q[c] <= 1'b0;
        step_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      oct_q       <= oct_d;
      frac_q      <= frac_d;
      gl_q        <= gl_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      upd_valid_q <= upd_valid_d;
      upd_ch_q    <= upd_ch_d;
      note_q      <= note_d;
      bend_q      <= bend_d;
      gate_q      <= gate_d;
      step_q      <= step_d;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) step_flat[32*c +: 32] = step_q[c];
  end

  assign upd_valid = upd_valid_q;
  assign upd_ch    = upd_ch_q;

endmodule

// File: tb/tb_note_step_engine.sv
// Directed bench for note_step_engine: 4 voices, 3-bit channel index so that
// out-of-range writes can be exercised.
module tb_note_step_engine;

  localparam int unsigned NCH = 4;
  localparam int unsigned CHB = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [CHB-1:0]   wr_ch;
  logic [6:0]       wr_note;
  logic [13:0]      wr_bend;
  logic             wr_gate;
  logic [32*NCH-1:0] step_flat;
  logic             upd_valid;
  logic [CHB-1:0]   upd_ch;

  int checks = 0;
  int errors = 0;

  note_step_engine #(.NUM_CHANNELS(NCH), .CH_BITS(CHB), .BEND_SEMIS(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_note(wr_note),
    .wr_bend(wr_bend), .wr_gate(wr_gate), .step_flat(step_flat),
    .upd_valid(upd_valid), .upd_ch(upd_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] step_of(input int ch);
    return step_flat[32*ch +: 32];
  endfunction

  task automatic wr(input int ch, input int note, input int bend, input logic gate);
    @(posedge clk); #1;
    wr_en   = 1'b1;
    wr_ch   = CHB'(ch);
    wr_note = 7'(note);
    wr_bend = 14'(bend);
    wr_gate = gate;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  task automatic wait_upd(input int ch);
    bit found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (upd_valid && upd_ch == CHB'(ch)) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $error("FAIL wait_upd_ch%0d: observed timeout expected update", ch);
    end
  endtask

  // Two updates guarantee the second one started after the write.
  task automatic set_and_check(input string tag, input int ch, input int note,
                               input int bend, input logic gate, input logic [31:0] exp);
    wr(ch, note, bend, gate);
    wait_upd(ch);
    wait_upd(ch);
    chk(tag, step_of(ch), exp);
  endtask

  int exp_ch;
  int last;
  int npulse;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_note = '0; wr_bend = '0; wr_gate = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_step_zero", 32'(step_flat == '0), 32'd1);
    chk("rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("rst_upd_ch", 32'(upd_ch), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Idle scan: gates off, order 0..3, pulses never back to back
    exp_ch = 0; last = -100; npulse = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (upd_valid) begin
        chk("scan_order", 32'(upd_ch), 32'(exp_ch));
        chk("scan_gap", 32'((i - last) >= 2), 32'd1);
        chk("scan_zero", 32'(step_flat == '0), 32'd1);
        last = i;
        npulse++;
        exp_ch = (exp_ch == 3) ? 0 : exp_ch + 1;
      end
    end
    chk("scan_count", 32'(npulse >= 5), 32'd1);

    set_and_check("ch0_n69", 0, 69, 8192, 1'b1, 32'd47244640);
    set_and_check("ch0_n60", 0, 60, 8192, 1'b1, 32'd28091830);
    set_and_check("ch0_n120", 0, 120, 8192, 1'b1, 32'd898938587);
    set_and_check("ch1_bend_half", 1, 108, 10240, 1'b1, 32'd462832708);
    set_and_check("ch2_clamp_hi", 2, 127, 16383, 1'b1, 32'd1346885960);
    set_and_check("ch3_clamp_lo", 3, 0, 0, 1'b1, 32'd877869);
    chk("hold_ch0", step_of(0), 32'd898938587);
    chk("hold_ch1", step_of(1), 32'd462832708);
    chk("hold_ch2", step_of(2), 32'd1346885960);

    set_and_check("ch0_gate_off", 0, 120, 8192, 1'b0, 32'd0);
    chk("gate_keep_ch1", step_of(1), 32'd462832708);
    chk("gate_keep_ch2", step_of(2), 32'd1346885960);
    chk("gate_keep_ch3", step_of(3), 32'd877869);

    // Out-of-range channel must not touch any voice
    wr(5, 69, 8192, 1'b1);
    wait_upd(3);
    wait_upd(3);
    chk("oor_ch0", step_of(0), 32'd0);
    chk("oor_ch1", step_of(1), 32'd462832708);
    chk("oor_ch2", step_of(2), 32'd1346885960);
    chk("oor_ch3", step_of(3), 32'd877869);

    // Reset while ch1 (note 108, long divide) is mid-computation
    wait_upd(0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_no_upd", 32'(upd_valid), 32'd0);
    chk("mid_pre_ch1", step_of(1), 32'd462832708);
    @(negedge clk);
    chk("mid_rst_step", 32'(step_flat == '0), 32'd1);
    chk("mid_rst_valid", 32'(upd_valid), 32'd0);
    chk("mid_rst_ch", 32'(upd_ch), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    npulse = 0;
    for (int i = 0; i < 50 && npulse == 0; i++) begin
      @(negedge clk);
      if (upd_valid) npulse = 1;
    end
    chk("restart_seen", 32'(npulse), 32'd1);
    chk("restart_ch0", 32'(upd_ch), 32'd0);
    chk("restart_zero", 32'(step_flat == '0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
